// File: rtl/barrel_shift_scheduler.sv
// Round-robin arbiter sharing one combinational barrel shifter between two requesters.
// Latency req->done 2 cycles, one transaction per 3 cycles; req is only sampled while idle.
module barrel_shift_scheduler #(
  parameter int WIDTH = 16,
  parameter int SHW   = 2
) (
  input  logic             bsched_clk,
  input  logic             bsched_rst,
  input  logic [1:0]       bsched_req,
  input  logic [WIDTH-1:0] bsched_data0,
  input  logic [WIDTH-1:0] bsched_data1,
  input  logic [SHW+1:0]   bsched_ctrl0,
  input  logic [SHW+1:0]   bsched_ctrl1,
  output logic [1:0]       bsched_gnt,
  output logic [1:0]       bsched_done,
  output logic [WIDTH-1:0] bsched_result,
  output logic             bsched_busy,
  output logic [WIDTH-1:0] bsched_sh_in,
  output logic [SHW-1:0]   bsched_sh_shift,
  output logic             bsched_sh_sr,
  output logic             bsched_sh_dir,
  input  logic [WIDTH-1:0] bsched_sh_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]       state;
  logic             last_gnt;
  logic             win;
  logic [WIDTH-1:0] win_data;
  logic [SHW+1:0]   win_ctrl;

  // On a tie the requester not served last wins; a lone request wins outright.
  always_comb begin
    win      = (bsched_req == 2'b11) ? ~last_gnt : bsched_req[1];
    win_data = win ? bsched_data1 : bsched_data0;
    win_ctrl = win ? bsched_ctrl1 : bsched_ctrl0;
  end

  assign bsched_busy = (state != IDLE);

  always_ff @(posedge bsched_clk) begin
    if (bsched_rst) begin
      state           <= IDLE;
      last_gnt        <= 1'b1;
      bsched_gnt      <= 2'b00;
      bsched_done     <= 2'b00;
      bsched_result   <= '0;
      bsched_sh_in    <= '0;
      bsched_sh_shift <= '0;
      bsched_sh_sr    <= 1'b0;
      bsched_sh_dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bsched_req) begin
            bsched_sh_in    <= win_data;
            bsched_sh_shift <= win_ctrl[SHW-1:0];
            bsched_sh_dir   <= win_ctrl[SHW];
            bsched_sh_sr    <= win_ctrl[SHW+1];
            bsched_gnt      <= win ? 2'b10 : 2'b01;
            last_gnt        <= win;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          bsched_result <= bsched_sh_out;
          bsched_done   <= bsched_gnt;
          state         <= CAPTURE;
        end
        CAPTURE: begin
          bsched_gnt  <= 2'b00;
          bsched_done <= 2'b00;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_scheduler.sv
// Bench for barrel_shift_scheduler: directed scenarios plus random traffic against a transaction model.
module tb_barrel_shift_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] data0, data1;
  logic [3:0]  ctrl0, ctrl1;
  logic [1:0]  gnt, done;
  logic [15:0] result, sh_in, sh_out;
  logic        busy, sh_sr, sh_dir;
  logic [1:0]  sh_shift;

  int n_cmp = 0;
  int n_err = 0;

  // model: phase counts cycles since grant (0 = idle)
  int          m_phase;
  int          m_win;
  int          m_last;
  logic [15:0] m_result, m_in;
  logic [1:0]  m_shift;
  logic        m_sr, m_dir;

  always #5 clk = ~clk;

  barrel_shift_scheduler #(.WIDTH(16), .SHW(2)) dut (
    .bsched_clk(clk), .bsched_rst(rst), .bsched_req(req),
    .bsched_data0(data0), .bsched_data1(data1),
    .bsched_ctrl0(ctrl0), .bsched_ctrl1(ctrl1),
    .bsched_gnt(gnt), .bsched_done(done), .bsched_result(result), .bsched_busy(busy),
    .bsched_sh_in(sh_in), .bsched_sh_shift(sh_shift), .bsched_sh_sr(sh_sr),
    .bsched_sh_dir(sh_dir), .bsched_sh_out(sh_out)
  );

  function automatic logic [15:0] shf(input logic [15:0] x, input logic [1:0] n,
                                      input logic sr, input logic dir);
    logic [31:0] d;
    d = {x, x};
    if (sr && dir)  begin d = d >> n; return d[15:0];  end
    if (sr && !dir) begin d = d << n; return d[31:16]; end
    if (dir) return x >> n;
    return x << n;
  endfunction

  always_comb sh_out = shf(sh_in, sh_shift, sh_sr, sh_dir);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_phase = 0; m_last = 1; m_result = 0; m_in = 0; m_shift = 0; m_sr = 0; m_dir = 0;
    end else if (m_phase == 0) begin
      if (req != 2'b00) begin
        m_win = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
        m_last = m_win;
        m_in    = m_win ? data1 : data0;
        m_shift = m_win ? ctrl1[1:0] : ctrl0[1:0];
        m_dir   = m_win ? ctrl1[2] : ctrl0[2];
        m_sr    = m_win ? ctrl1[3] : ctrl0[3];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_result = shf(m_in, m_shift, m_sr, m_dir);
      m_phase  = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_all();
    logic [1:0] one;
    one = (m_win == 1) ? 2'b10 : 2'b01;
    check_val("gnt",    gnt,    (m_phase != 0) ? one : 2'b00);
    check_val("done",   done,   (m_phase == 2) ? one : 2'b00);
    check_val("busy",   busy,   m_phase != 0);
    check_val("result", result, m_result);
    check_val("sh_in",  sh_in,  m_in);
    check_val("sh_ctl", {sh_sr, sh_dir, sh_shift}, {m_sr, m_dir, m_shift});
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    m_phase = 0; m_win = 0; m_last = 1;
    m_result = 0; m_in = 0; m_shift = 0; m_sr = 0; m_dir = 0;
    rst = 1; req = 2'b11; data0 = 16'h1111; data1 = 16'h2222; ctrl0 = 4'h1; ctrl1 = 4'h2;

    // reset with both requesting, first grant goes to requester 0
    step(); step();
    rst = 0;
    step();
    check_val("rst_first_gnt", gnt, 2'b01);
    req = 2'b00;
    repeat (3) step();

    // single request, rotate right by 1
    data0 = 16'h1234; ctrl0 = 4'b1101; req = 2'b01;
    step();
    req = 2'b00;
    step();
    check_val("single_done", done, 2'b01);
    check_val("single_res",  result, 16'h091A);
    step();
    check_val("single_busy", busy, 1'b0);
    repeat (2) step();

    // contention: grants alternate
    data0 = 16'h00F0; ctrl0 = 4'b0010; data1 = 16'h8001; ctrl1 = 4'b1001; req = 2'b11;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done != 2'b00) check_val("cont_res", result, (done == 2'b01) ? 16'h03C0 : 16'h0003);
    end
    req = 2'b00;
    repeat (3) step();

    // request withdrawn during ISSUE
    data1 = 16'h0F0F; ctrl1 = 4'b0101; req = 2'b10;
    step();
    req = 2'b00;
    step();
    check_val("wd_done", done, 2'b10);
    repeat (3) step();
    check_val("wd_nogrant", gnt, 2'b00);

    // reset during CAPTURE
    req = 2'b11;
    step(); step();
    check_val("mid_capture", busy, 1'b1);
    rst = 1;
    step();
    check_val("mid_done", done, 2'b00);
    check_val("mid_res",  result, 16'h0000);
    rst = 0;
    step();
    check_val("mid_tie_gnt", gnt, 2'b01);
    req = 2'b00;
    repeat (3) step();

    // pass-through
    data0 = 16'hBEEF; ctrl0 = 4'b0000; req = 2'b01;
    step();
    req = 2'b00;
    repeat (4) step();
    check_val("pass_res",   result, 16'hBEEF);
    check_val("pass_sh_in", sh_in, 16'hBEEF);
    check_val("pass_shift", sh_shift, 2'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      req   = 2'($urandom_range(0, 3));
      data0 = 16'($urandom);
      data1 = 16'($urandom);
      ctrl0 = 4'($urandom);
      ctrl1 = 4'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
